counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 98 +++++++++
 tb/tb_counter_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Purpose: run-controlled up/down counter with pause, loop-reload and one-shot done.
// Latency: all outputs registered; start is acted on at the first edge it is seen in IDLE.
// Backpressure: pause freezes the count in place; clear aborts to IDLE from any state.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             dir,
  input  logic             loop,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           st;
  logic             dir_q;
  logic             loop_q;
  logic [WIDTH-1:0] limit_q;
  logic             terminal;

  // Run settings are captured at start, so the terminal value only depends on latched copies.
  assign terminal = dir_q ? (count == limit_q) : (count == '0);
  assign state    = st;

  // Single FSM register: state, count and all status outputs update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      dir_q   <= 1'b1;
      loop_q  <= 1'b0;
      limit_q <= '0;
    end else begin
      // Pulses default low; they are only raised on the edge that causes them.
      done <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        st    <= IDLE;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (start) begin
              dir_q   <= dir;
              loop_q  <= loop;
              limit_q <= limit;
              st      <= RUN;
              busy    <= 1'b1;
              count   <= dir ? '0 : limit;
            end
          end
          RUN: begin
            // Pause outranks the terminal check: no advance, no done, no wrap.
            if (pause) begin
              st <= PAUSE;
            end else if (terminal) begin
              if (loop_q) begin
                count <= dir_q ? '0 : limit_q;
                wrap  <= 1'b1;
              end else begin
                st   <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else begin
              count <= dir_q ? count + 1'b1 : count - 1'b1;
            end
          end
          PAUSE: begin
            if (!pause) st <= RUN;
          end
          DONE: begin
            st <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       clear;
  logic       dir;
  logic       loop;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       wrap;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  counter_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .pause (pause),
    .clear (clear),
    .dir   (dir),
    .loop  (loop),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    dir = 1'b1; loop = 1'b0; limit = 4'd0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_state", state, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_wrap",  wrap, 0);
    #10 rst = 1'b1;
    step();

    // Up to 3, no loop; settings changed after start must be ignored.
    dir = 1'b1; loop = 1'b0; limit = 4'd3; start = 1'b1;
    step();
    start = 1'b0; limit = 4'd1; dir = 1'b0; loop = 1'b1;
    chk("up_c0", count, 0);
    chk("up_st_run", state, 1);
    chk("up_busy", busy, 1);
    step(); chk("up_c1", count, 1);
    step(); chk("up_c2", count, 2);
    step(); chk("up_c3", count, 3);
    step();
    chk("up_done_st", state, 3);
    chk("up_done", done, 1);
    chk("up_done_cnt", count, 3);
    chk("up_done_busy", busy, 0);
    step();
    chk("up_idle_st", state, 0);
    chk("up_idle_done", done, 0);
    chk("up_idle_cnt", count, 3);

    // Down from 2 with loop: reload pulses wrap, never done.
    dir = 1'b0; loop = 1'b1; limit = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("dn_c2", count, 2);
    chk("dn_wrap0", wrap, 0);
    step(); chk("dn_c1", count, 1);
    step(); chk("dn_c0", count, 0);
    step();
    chk("dn_reload", count, 2);
    chk("dn_wrap1", wrap, 1);
    chk("dn_busy", busy, 1);
    step();
    chk("dn_c1b", count, 1);
    chk("dn_wrap_low", wrap, 0);
    step(); chk("dn_c0b", count, 0);
    step();
    chk("dn_reload2", count, 2);
    chk("dn_wrap2", wrap, 1);
    chk("dn_nodone", done, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("dn_clr_st", state, 0);
    chk("dn_clr_cnt", count, 0);
    chk("dn_clr_wrap", wrap, 0);
    chk("dn_clr_busy", busy, 0);

    // Up to 15 with pause at 5 and pause coincident with terminal.
    dir = 1'b1; loop = 1'b0; limit = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    steps(5);
    chk("ps_c5", count, 5);
    pause = 1'b1;
    step(); chk("ps_st_a", state, 2); chk("ps_hold_a", count, 5); chk("ps_busy", busy, 1);
    step(); chk("ps_st_b", state, 2); chk("ps_hold_b", count, 5);
    step(); chk("ps_st_c", state, 2); chk("ps_hold_c", count, 5);
    pause = 1'b0;
    step(); chk("ps_resume_st", state, 1); chk("ps_resume_cnt", count, 5);
    step(); chk("ps_c6", count, 6);
    steps(9);
    chk("ps_c15", count, 15);
    pause = 1'b1;
    step();
    chk("ps_term_st", state, 2);
    chk("ps_term_nodone", done, 0);
    pause = 1'b0;
    step();
    chk("ps_term_run", state, 1);
    chk("ps_term_nodone2", done, 0);
    step();
    chk("ps_term_done", done, 1);
    chk("ps_term_dst", state, 3);
    step();
    chk("ps_term_idle", state, 0);

    // Clear with start both high at count 7.
    dir = 1'b1; loop = 1'b0; limit = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    steps(7);
    chk("cl_c7", count, 7);
    clear = 1'b1; start = 1'b1;
    step();
    chk("cl_st", state, 0);
    chk("cl_cnt", count, 0);
    chk("cl_done", done, 0);
    chk("cl_busy", busy, 0);
    clear = 1'b0; start = 1'b0;
    step();
    chk("cl_stay_idle", state, 0);

    // Asynchronous reset mid-run at count 9.
    start = 1'b1;
    step();
    start = 1'b0;
    steps(9);
    chk("ar_c9", count, 9);
    #2 rst = 1'b0;
    #1;
    chk("ar_cnt", count, 0);
    chk("ar_st", state, 0);
    chk("ar_busy", busy, 0);
    #2 rst = 1'b1;
    step();
    chk("ar_wait_idle", state, 0);
    dir = 1'b1; limit = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    chk("ar_fresh_st", state, 1);
    chk("ar_fresh_c0", count, 0);
    step();
    chk("ar_fresh_c1", count, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // limit = 0 down: start value 0 is already terminal.
    dir = 1'b0; loop = 1'b0; limit = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("z_dn_run", state, 1);
    chk("z_dn_c0", count, 0);
    step();
    chk("z_dn_done_st", state, 3);
    chk("z_dn_done", done, 1);
    chk("z_dn_cnt", count, 0);
    step();
    chk("z_dn_idle", state, 0);

    // limit = 0 up, with limit raised during the run.
    dir = 1'b1; limit = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("z_up_run", state, 1);
    limit = 4'd5;
    step();
    chk("z_up_done_st", state, 3);
    chk("z_up_done", done, 1);
    chk("z_up_cnt", count, 0);
    chk("z_up_wrap", wrap, 0);
    step();
    chk("z_up_idle", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
